// File: rtl/control_unit_pkg.sv
// Shared opcode, state and IR-field definitions for the control unit and data path.
package control_unit_pkg;

    localparam int OPC_HI = 31;
    localparam int OPC_LO = 27;
    localparam int RA_HI  = 26;
    localparam int RA_LO  = 23;
    localparam int RB_HI  = 22;
    localparam int RB_LO  = 19;
    localparam int RC_HI  = 18;
    localparam int RC_LO  = 15;

    localparam logic [4:0] OP_AND  = 5'b00001;
    localparam logic [4:0] OP_OR   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    typedef enum logic [3:0] {
        ST_RST    = 4'd0,
        ST_T0     = 4'd1,
        ST_T1     = 4'd2,
        ST_T2     = 4'd3,
        ST_T3     = 4'd4,
        ST_T4     = 4'd5,
        ST_T5     = 4'd6,
        ST_T6     = 4'd7,
        ST_HALTED = 4'd8
    } state_t;

    function automatic logic is_alu(input logic [4:0] opc);
        return (opc == OP_AND) || (opc == OP_OR) || (opc == OP_ADD) ||
               (opc == OP_SUB) || (opc == OP_MUL);
    endfunction

endpackage

// File: rtl/control_unit_if.sv
// Instruction/halt inputs and all strobes between the control unit and the data path.
interface control_unit_if;
    logic [31:0] IR;
    logic        stop;
    logic        PCout, MDRout, Zhighout, Zlowout, HIout, LOout;
    logic        MARin, PCin, IncPC, Read, MDRin, IRin, Yin, ZHighin, Zlowin, HIin, LOin;
    logic [15:0] Rout_sel;
    logic [15:0] Rin_sel;
    logic [4:0]  op;
    logic        run, retired, illegal;
    logic [3:0]  step;

    modport master (
        input  IR, stop,
        output PCout, MDRout, Zhighout, Zlowout, HIout, LOout,
        output MARin, PCin, IncPC, Read, MDRin, IRin, Yin, ZHighin, Zlowin, HIin, LOin,
        output Rout_sel, Rin_sel, op, run, retired, illegal, step
    );

    modport slave (
        output IR, stop,
        input  PCout, MDRout, Zhighout, Zlowout, HIout, LOout,
        input  MARin, PCin, IncPC, Read, MDRin, IRin, Yin, ZHighin, Zlowin, HIin, LOin,
        input  Rout_sel, Rin_sel, op, run, retired, illegal, step
    );
endinterface

// File: rtl/control_unit_reg_decoder.sv
// 4-bit register index to 16-bit one-hot select; all zero when disabled.
module reg_decoder (
    input  logic [3:0]  i_idx,
    input  logic        i_en,
    output logic [15:0] o_onehot
);
    always_comb begin
        o_onehot = '0;
        if (i_en)
            o_onehot[i_idx] = 1'b1;
    end
endmodule

// File: rtl/control_unit.sv
// Moore sequencer for fetch / ALU execute / halt; outputs decode from state and IR only.
module control_unit
    import control_unit_pkg::*;
(
    input  logic           Clock,
    input  logic           clear,
    control_unit_if.master bus
);
    state_t      r_state, w_next;
    logic [4:0]  w_opc;
    logic [3:0]  w_ra, w_rb, w_rc;
    logic        w_mul, w_rout_en, w_rin_en;
    logic [3:0]  w_rout_idx;
    logic [15:0] w_rout, w_rin;

    assign w_opc = bus.IR[OPC_HI:OPC_LO];
    assign w_ra  = bus.IR[RA_HI:RA_LO];
    assign w_rb  = bus.IR[RB_HI:RB_LO];
    assign w_rc  = bus.IR[RC_HI:RC_LO];
    assign w_mul = (w_opc == OP_MUL);

    always_ff @(posedge Clock or posedge clear) begin
        if (clear) r_state <= ST_RST;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next       = r_state;
        w_rout_en    = 1'b0;
        w_rout_idx   = w_rb;
        w_rin_en     = 1'b0;
        bus.PCout    = 1'b0; bus.MDRout = 1'b0; bus.Zhighout = 1'b0;
        bus.Zlowout  = 1'b0; bus.HIout  = 1'b0; bus.LOout    = 1'b0;
        bus.MARin    = 1'b0; bus.PCin   = 1'b0; bus.IncPC    = 1'b0;
        bus.Read     = 1'b0; bus.MDRin  = 1'b0; bus.IRin     = 1'b0;
        bus.Yin      = 1'b0; bus.ZHighin = 1'b0; bus.Zlowin  = 1'b0;
        bus.HIin     = 1'b0; bus.LOin   = 1'b0;
        bus.op       = '0;
        bus.retired  = 1'b0;
        bus.illegal  = 1'b0;
        case (r_state)
            ST_RST: w_next = ST_T0;
            ST_T0: begin
                bus.PCout = 1'b1; bus.MARin = 1'b1; bus.IncPC = 1'b1; bus.Zlowin = 1'b1;
                w_next = ST_T1;
            end
            ST_T1: begin
                bus.Zlowout = 1'b1; bus.PCin = 1'b1; bus.Read = 1'b1; bus.MDRin = 1'b1;
                w_next = ST_T2;
            end
            ST_T2: begin
                bus.MDRout = 1'b1; bus.IRin = 1'b1;
                w_next = ST_T3;
            end
            ST_T3: begin
                if (is_alu(w_opc)) begin
                    w_rout_en = 1'b1;
                    bus.Yin   = 1'b1;
                    w_next    = ST_T4;
                end else if (w_opc == OP_NOP) begin
                    bus.retired = 1'b1;
                    w_next      = ST_T0;
                end else if (w_opc == OP_HALT) begin
                    bus.retired = 1'b1;
                    w_next      = ST_HALTED;
                end else begin
                    bus.illegal = 1'b1;
                    w_next      = ST_T0;
                end
            end
            ST_T4: begin
                w_rout_en   = 1'b1;
                w_rout_idx  = w_rc;
                bus.op      = w_opc;
                bus.Zlowin  = 1'b1;
                bus.ZHighin = w_mul;
                w_next      = ST_T5;
            end
            ST_T5: begin
                bus.Zlowout = 1'b1;
                if (w_mul) begin
                    bus.LOin = 1'b1;
                    w_next   = ST_T6;
                end else begin
                    w_rin_en    = 1'b1;
                    bus.retired = 1'b1;
                    w_next      = ST_T0;
                end
            end
            ST_T6: begin
                bus.Zhighout = 1'b1; bus.HIin = 1'b1; bus.retired = 1'b1;
                w_next = ST_T0;
            end
            ST_HALTED: w_next = ST_HALTED;
            default:   w_next = ST_RST;
        endcase
        // A pending stop diverts only at an instruction boundary, never out of reset
        if (w_next == ST_T0 && r_state != ST_RST && bus.stop)
            w_next = ST_HALTED;
    end

    reg_decoder u_rout_dec (.i_idx(w_rout_idx), .i_en(w_rout_en), .o_onehot(w_rout));
    reg_decoder u_rin_dec  (.i_idx(w_ra),       .i_en(w_rin_en),  .o_onehot(w_rin));

    assign bus.Rout_sel = w_rout;
    assign bus.Rin_sel  = w_rin;
    assign bus.run      = (r_state != ST_RST) && (r_state != ST_HALTED);
    assign bus.step     = r_state;
endmodule
